// File: rtl/sha_pipelined_stream_padder.sv
// SHA-256 message padder: accepts a stream of 32-bit words and emits padded 512-bit blocks,
// spilling terminator/length into an extra block when the message tail does not fit.
module sha_pipelined_stream_padder #(
    parameter int unsigned LEN_W = 32,
    parameter int unsigned ORDER = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       word_i,
    input  logic              valid_i,
    input  logic              last_i,
    input  logic              newblock_i,
    output logic              ready_o,
    output logic [15:0][31:0] padded,
    output logic              valid_o,
    output logic              newblock_o,
    output logic              last_o,
    input  logic              ready_i
);

    localparam logic [31:0] PAD_WORD = 32'h8000_0000;

    typedef enum logic {
        S_FILL,
        S_EXTRA
    } state_t;

    state_t            state_q, state_d;
    logic [15:0][31:0] acc_q, acc_d;
    logic [3:0]        n_q, n_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              tag_q, tag_d;
    logic              in_msg_q, in_msg_d;
    logic              pad15_q, pad15_d;
    logic [15:0][31:0] padded_q, padded_d;
    logic              valid_q, valid_d;
    logic              newblock_q, newblock_d;
    logic              last_q, last_d;

    logic              out_free;
    logic              ready;
    logic              accept;
    logic              capture;
    logic              tag_eff;
    logic [LEN_W-1:0]  len_inc;
    logic [63:0]       len_new64;
    logic [63:0]       len_old64;
    logic [15:0][31:0] blk;
    logic [15:0][31:0] ext;

    // ORDER=1 maps padded[k] to block word (16-k) mod 16.
    function automatic logic [15:0][31:0] reorder(input logic [15:0][31:0] b);
        logic [15:0][31:0] r;
        r = b;
        if (ORDER != 0) begin
            for (int unsigned k = 0; k < 16; k++) begin
                r[k[3:0]] = b[4'd0 - k[3:0]];
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        n_d        = n_q;
        len_d      = len_q;
        tag_d      = tag_q;
        in_msg_d   = in_msg_q;
        pad15_d    = pad15_q;
        padded_d   = padded_q;
        valid_d    = valid_q;
        newblock_d = newblock_q;
        last_d     = last_q;

        out_free = !valid_q || ready_i;
        ready    = (state_q == S_FILL) && out_free;
        accept   = valid_i && ready;
        capture  = (n_q == 4'd0) && !in_msg_q;
        tag_eff  = capture ? newblock_i : tag_q;
        len_inc  = len_q + LEN_W'(32);

        len_new64            = '0;
        len_new64[LEN_W-1:0] = len_inc;
        len_old64            = '0;
        len_old64[LEN_W-1:0] = len_q;

        // Block completed by the current word: buffered data, this word, then padding.
        blk = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i[3:0] < n_q) begin
                blk[i[3:0]] = acc_q[i[3:0]];
            end
        end
        blk[n_q] = word_i;
        if (last_i && (n_q != 4'd15)) begin
            blk[n_q + 4'd1] = PAD_WORD;
        end
        if (last_i && (n_q <= 4'd12)) begin
            blk[14] = len_new64[63:32];
            blk[15] = len_new64[31:0];
        end

        ext = '0;
        if (pad15_q) begin
            ext[0] = PAD_WORD;
        end
        ext[14] = len_old64[63:32];
        ext[15] = len_old64[31:0];

        if (accept) begin
            acc_d[n_q] = word_i;
            len_d      = len_inc;
            in_msg_d   = 1'b1;
            if (capture) begin
                tag_d = newblock_i;
            end
            if (!last_i) begin
                if (n_q == 4'd15) begin
                    padded_d   = reorder(blk);
                    valid_d    = 1'b1;
                    last_d     = 1'b0;
                    newblock_d = tag_eff;
                    n_d        = 4'd0;
                    tag_d      = 1'b0;
                end else begin
                    n_d     = n_q + 4'd1;
                    valid_d = 1'b0;
                end
            end else if (n_q <= 4'd12) begin
                padded_d   = reorder(blk);
                valid_d    = 1'b1;
                last_d     = 1'b1;
                newblock_d = tag_eff;
                n_d        = 4'd0;
                len_d      = '0;
                tag_d      = 1'b0;
                in_msg_d   = 1'b0;
            end else begin
                // Tail does not leave room for the length; keep L for the extra block.
                padded_d   = reorder(blk);
                valid_d    = 1'b1;
                last_d     = 1'b0;
                newblock_d = tag_eff;
                pad15_d    = (n_q == 4'd15);
                n_d        = 4'd0;
                state_d    = S_EXTRA;
            end
        end else if ((state_q == S_EXTRA) && out_free) begin
            padded_d   = reorder(ext);
            valid_d    = 1'b1;
            last_d     = 1'b1;
            newblock_d = 1'b0;
            state_d    = S_FILL;
            n_d        = 4'd0;
            len_d      = '0;
            tag_d      = 1'b0;
            in_msg_d   = 1'b0;
            pad15_d    = 1'b0;
        end else if (out_free) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FILL;
            acc_q      <= '0;
            n_q        <= 4'd0;
            len_q      <= '0;
            tag_q      <= 1'b0;
            in_msg_q   <= 1'b0;
            pad15_q    <= 1'b0;
            padded_q   <= '0;
            valid_q    <= 1'b0;
            newblock_q <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            n_q        <= n_d;
            len_q      <= len_d;
            tag_q      <= tag_d;
            in_msg_q   <= in_msg_d;
            pad15_q    <= pad15_d;
            padded_q   <= padded_d;
            valid_q    <= valid_d;
            newblock_q <= newblock_d;
            last_q     <= last_d;
        end
    end

    assign ready_o    = ready;
    assign padded     = padded_q;
    assign valid_o    = valid_q;
    assign newblock_o = newblock_q;
    assign last_o     = last_q;

endmodule

// File: doc/sha_pipelined_stream_padder.md
Name: sha_pipelined_stream_padder

Overview:
Parametrised SHA-256 message padder that takes a stream of 32-bit message words and emits padded 512-bit blocks. It places the 0x80000000 terminator, zero fill and 64-bit bit-length field, and adds an extra block when padding spills over a block boundary. It generalises the fixed 8-word second-hash padder to any whole-word message length, adds valid/ready backpressure, and offers a selectable output word ordering. It sits between the message/digest source and the super-pipelined compression core.

Parameters:
LEN_W, 32, width of the bit-length counter; legal range 32..64; the count wraps modulo 2^LEN_W.
ORDER, 0, output word ordering. 0 = natural (padded[k] = block word k). 1 = reversed-wrap (padded[k] = block word (16-k) mod 16), the ordering the pipelined message schedule consumes.

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
word_i  input  32  message word
valid_i  input  1  word_i valid
last_i  input  1  word_i is the final word of the message
newblock_i  input  1  job tag; sampled on the first word of a message
ready_o  output  1  padder accepts word_i this cycle
padded  output  16x32  padded block, ordered per ORDER
valid_o  output  1  padded valid
newblock_o  output  1  tag of the message's first block
last_o  output  1  final block of the message
ready_i  input  1  downstream accepts the block

Behaviour:
- Word accept = valid_i && ready_o. Block transfer = valid_o && ready_i.
- Reset (priority over everything): valid_o=0, newblock_o=0, last_o=0, padded=0, state=FILL, word index n=0, bit length=0, tag=0. Reset mid-message discards all partial state.
- Storage: a 16-word accumulation buffer plus a separate registered output block. All outputs are registered.
- ready_o = (state==FILL) && (!valid_o || ready_i).
- FILL: each accept writes word_i into buffer[n] and adds 32 to the bit length.
  - When n==0, the tag is captured from newblock_i.
  - If !last_i and n==15: the next cycle loads the output with the full buffer, valid_o=1, last_o=0, newblock_o=tag if this is the message's first block (else 0). Then n resets to 0 and the tag clears.
  - If !last_i and n<15: n increments.
- Last word at index n (length L includes this word):
  - n<=12: single final block. Words 0..n = data, word n+1 = 0x80000000, zeros up to word 13, word14 = L[63:32] (0 if LEN_W<=32), word15 = L[31:0]. last_o=1. Next state FILL; n, L and tag reset.
  - n in 13..15: first block = data, word n+1 = 0x80000000 if n<15, remaining words 0, last_o=0. Next state EXTRA.
- EXTRA: ready_o=0. When !valid_o || ready_i, load the extra block: word0 = 0x80000000 only if n was 15, other words 0, word14/15 = length. Set last_o=1 and newblock_o=0. Next state FILL; n, L and tag reset.
- Latency: a block appears on the cycle after the accept that completes it; the extra block appears at least one cycle after the first.
- Backpressure: while valid_o && !ready_i, padded, valid_o, last_o and newblock_o hold stable.
- A transfer and an accept in the same cycle are legal; the output register is reloaded only when a new block is ready, otherwise valid_o drops to 0.
- A message longer than one block raises newblock_o only on its first block.
- ORDER remapping is applied when the output register is loaded.

Test Plan:
- ORDER=0, single word 0xDEADBEEF with last -> one block: w0=DEADBEEF, w1=80000000, w2..14=0, w15=0x20; last_o=1; valid_o asserted one cycle after the accept.
- ORDER=1, 8 words A..H (last on H), newblock_i=1 -> padded[0]=A, [1]=0x100, [2..7]=0, [8]=80000000, [9]=H, [10]=G ... [15]=B; newblock_o=1, last_o=1.
- ORDER=0, 14 words -> block1: w14=80000000, w15=0, last_o=0; block2: all zero except w15=0x1C0, last_o=1, newblock_o=0.
- ORDER=0, 16 words -> block1 = data, last_o=0; block2: w0=80000000, w15=0x200, last_o=1; ready_o=0 during EXTRA.
- ready_i held 0 for 5 cycles with valid_o=1 -> padded, valid_o and last_o stable, ready_o=0; the block is taken on the cycle ready_i=1, and the next word is accepted in that same cycle.
- rst pulsed after 5 words of a message -> all outputs 0. A subsequent 1-word message produces w15=0x20, confirming the length counter was cleared.
